// File: rtl/selector_sequencer_if.sv
// rtl/selector_sequencer_if.sv - requester and selector-side signals of the selector sequencer
interface selector_sequencer_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 12
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        done;
    logic [ADDR_W-1:0]       sel_addr;
    logic                    sel_en;
    logic                    busy;
    logic [ID_W-1:0]         active_id;

    modport master (
        output req_valid, req_addr,
        input  req_ready, done, sel_addr, sel_en, busy, active_id
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, done, sel_addr, sel_en, busy, active_id
    );
endinterface

// File: rtl/selector_sequencer.sv
// rtl/selector_sequencer.sv - round-robin owner of a one-hot line selector with setup/hold/turnaround timing
module selector_sequencer #(
    parameter int N_REQ        = 4,
    parameter int ADDR_W       = 12,
    parameter int SETUP_CYCLES = 4,
    parameter int HOLD_CYCLES  = 8
) (
    input  logic              clk,
    input  logic              rst,
    selector_sequencer_if.slave bus
);
    localparam int ID_W    = $clog2(N_REQ);
    localparam int MAX_CYC = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, GAP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic [N_REQ-1:0]   ready_q, ready_d;
    logic [N_REQ-1:0]   done_q, done_d;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [ADDR_W-1:0]  addr_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_addr
        assign addr_arr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
    end

    // Rotating priority: first valid requester at or after the pointer wins.
    always_comb begin
        int idx;
        logic [ID_W-1:0] cand;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = ID_W'(idx);
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        en_d    = 1'b0;
        ready_d = '0;
        done_d  = '0;
        case (state_q)
            IDLE: begin
                busy_d = win_found;
                if (win_found) begin
                    state_d         = SETUP;
                    cnt_d           = CNT_W'(SETUP_CYCLES - 1);
                    id_d            = win_id;
                    addr_d          = addr_arr[win_id];
                    ready_d[win_id] = 1'b1;
                    ptr_d           = (int'(win_id) == N_REQ - 1) ? '0 : win_id + 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ACTIVE;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                    en_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACTIVE: begin
                if (cnt_q == '0) begin
                    state_d      = GAP;
                    done_d[id_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    en_d  = 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Reset also discards any in-flight transaction, so no done pulse escapes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            id_q    <= '0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.done      = done_q;
    assign bus.sel_addr  = addr_q;
    assign bus.sel_en    = en_q;
    assign bus.busy      = busy_q;
    assign bus.active_id = id_q;
endmodule

// File: tb/tb_selector_sequencer.sv
// tb/tb_selector_sequencer.sv - randomized self-checking bench for selector_sequencer against a transaction timeline model
module tb_selector_sequencer;
    localparam int N  = 4;
    localparam int AW = 12;
    localparam int S  = 4;
    localparam int H  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    selector_sequencer_if #(.N_REQ(N), .ADDR_W(AW)) bus ();

    selector_sequencer #(
        .N_REQ(N), .ADDR_W(AW), .SETUP_CYCLES(S), .HOLD_CYCLES(H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Behavioural stand-in for the 4096-line one-hot selector.
    logic [4095:0] sel_out;
    assign sel_out = bus.sel_en ? (4096'(1) << bus.sel_addr) : '0;

    int total = 0;
    int bad   = 0;

    logic          pend  [N];
    logic [AW-1:0] raddr [N];
    bit            rearm = 0;
    bit            rnd   = 0;

    // Timeline model: m_t = cycles since the grant edge, -1 when idle.
    int            m_t     = -1;
    int            m_owner = 0;
    int            m_ptr   = 0;
    logic [AW-1:0] m_addr  = '0;
    int            cyc     = 0;
    int            grant_id  [$];
    int            grant_cyc [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit any_pend();
        bit r = 0;
        for (int k = 0; k < N; k++) if (pend[k]) r = 1;
        return r;
    endfunction

    task automatic step();
        logic [N*AW-1:0] pa;
        logic [N-1:0]    v;
        int              w;
        int              idx;
        for (int k = 0; k < N; k++) begin
            v[k]           = pend[k];
            pa[k*AW +: AW] = raddr[k];
        end
        bus.req_valid = v;
        bus.req_addr  = pa;

        if (rst) begin
            m_t = -1; m_ptr = 0; m_owner = 0; m_addr = '0;
        end else if (m_t < 0) begin
            w = -1;
            for (int i = 0; i < N; i++) begin
                idx = (m_ptr + i) % N;
                if (w < 0 && pend[idx]) w = idx;
            end
            if (w >= 0) begin
                m_t = 0; m_owner = w; m_addr = raddr[w]; m_ptr = (w + 1) % N;
                grant_id.push_back(w);
                grant_cyc.push_back(cyc);
            end
        end else if (m_t == S + H) begin
            m_t = -1;
        end else begin
            m_t++;
        end

        @(posedge clk);
        #1;
        cyc++;

        check("req_ready", 64'(bus.req_ready), (m_t == 0) ? 64'(1) << m_owner : 64'(0));
        check("done",      64'(bus.done),      (m_t == S + H) ? 64'(1) << m_owner : 64'(0));
        check("sel_en",    64'(bus.sel_en),    64'(m_t >= S && m_t < S + H));
        check("busy",      64'(bus.busy),      64'(m_t >= 0));
        check("sel_addr",  64'(bus.sel_addr),  64'(m_addr));
        check("active_id", 64'(bus.active_id), 64'(m_owner));
        if (m_t >= S && m_t < S + H) begin
            check("sel_bit", 64'(sel_out[m_addr]), 64'(1));
            check("sel_onehot", 64'($countones(sel_out)), 64'(1));
            if (int'(m_addr) > 0)    check("sel_below", 64'(sel_out[int'(m_addr) - 1]), 64'(0));
            if (int'(m_addr) < 4095) check("sel_above", 64'(sel_out[int'(m_addr) + 1]), 64'(0));
        end

        for (int k = 0; k < N; k++) begin
            if (bus.req_ready[k]) pend[k] = 1'b0;
            if (rearm && bus.done[k]) pend[k] = 1'b1;
            if (rnd && !pend[k] && $urandom_range(0, 7) == 0) begin
                pend[k]  = 1'b1;
                raddr[k] = AW'($urandom_range(0, 4094));
            end
        end
    endtask

    task automatic run_grants(input int target, input int budget, input string tag);
        int n = 0;
        while (grant_id.size() < target && n < budget) begin
            step();
            n++;
        end
        if (grant_id.size() < target) check({tag, "_timeout"}, 64'(grant_id.size()), 64'(target));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((m_t >= 0 || any_pend()) && n < budget) begin
            step();
            n++;
        end
        if (m_t >= 0 || any_pend()) check("drain_timeout", 64'(n), 64'(0));
    endtask

    initial begin
        int base;
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            pend[k]  = 1'b1;
            raddr[k] = AW'(k + 100);
        end

        // Reset held with every request active: everything stays zero.
        repeat (3) step();
        check("reset_busy", 64'(bus.busy), 64'(0));
        check("reset_ready", 64'(bus.req_ready), 64'(0));

        rst = 1'b0;
        grant_id.delete();
        grant_cyc.delete();
        run_grants(1, 20, "first");
        if (grant_id.size() >= 1) check("first_grant", 64'(grant_id[0]), 64'(0));
        for (int k = 1; k < N; k++) pend[k] = 1'b0;
        drain(40);

        // Single request on requester 2 at line 12.
        pend[2] = 1'b1; raddr[2] = 12'd12;
        base = grant_id.size();
        run_grants(base + 1, 20, "single");
        if (grant_id.size() > base) check("single_grant", 64'(grant_id[base]), 64'(2));
        drain(40);

        // Round robin from a fresh pointer; requesters re-arm on done.
        rst = 1'b1; step(); rst = 1'b0;
        raddr[0] = 12'd1; raddr[1] = 12'd2; raddr[2] = 12'd3; raddr[3] = 12'd4095;
        for (int k = 0; k < N; k++) pend[k] = 1'b1;
        rearm = 1;
        base = grant_id.size();
        run_grants(base + 5, 120, "rr");
        rearm = 0;
        for (int k = 0; k < N; k++) pend[k] = 1'b0;
        if (grant_id.size() >= base + 5) begin
            for (int i = 0; i < 5; i++) check("rr_order", 64'(grant_id[base + i]), 64'(i % 4));
            for (int i = 1; i < 5; i++)
                check("rr_period", 64'(grant_cyc[base + i] - grant_cyc[base + i - 1]), 64'(14));
        end
        drain(40);

        // Pointer now at 1: requester 3 must beat requester 0.
        pend[0] = 1'b1; raddr[0] = 12'd500;
        pend[3] = 1'b1; raddr[3] = 12'd600;
        base = grant_id.size();
        run_grants(base + 2, 60, "skip");
        if (grant_id.size() >= base + 2) begin
            check("skip_first", 64'(grant_id[base]), 64'(3));
            check("skip_second", 64'(grant_id[base + 1]), 64'(0));
        end
        drain(40);

        // Reset in the third ACTIVE cycle aborts without a done pulse.
        pend[1] = 1'b1; raddr[1] = 12'd77;
        base = grant_id.size();
        run_grants(base + 1, 20, "abort");
        while (m_t >= 0 && m_t < S + 2) step();
        check("abort_en_before", 64'(bus.sel_en), 64'(1));
        rst = 1'b1; step(); rst = 1'b0;
        check("abort_en", 64'(bus.sel_en), 64'(0));
        check("abort_done", 64'(bus.done), 64'(0));
        repeat (3) step();
        pend[1] = 1'b1; pend[3] = 1'b1;
        base = grant_id.size();
        run_grants(base + 1, 20, "post_abort");
        if (grant_id.size() > base) check("abort_ptr", 64'(grant_id[base]), 64'(1));
        drain(60);

        // Random arrivals and addresses for ten more transactions.
        rnd = 1;
        base = grant_id.size();
        run_grants(base + 10, 2000, "random");
        rnd = 0;
        drain(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
